rr_arbiter_5req: RTL and testbench
==================================

// Module: rr_arbiter_5req
// PURPOSE
//  5-requester round-robin arbiter; one registered one-hot grant held until release.
//  Sits directly upstream of encoder_5b_3b, which turns gnt[4:0] into a 3-bit index.
//  gnt therefore has exactly one bit set, or is all zero.
//  Grants are held until the owner releases them; a hold-time limit prevents starvation.
// PARAMETERS
//  MAX_HOLD  16  max cycles a grant may be held; 0 = no limit
//  CNT_W     5   hold counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  req       in   5  request vector, bit i = requester i, level-held
//  done      in   1  1-cycle release pulse from current owner
//  gnt       out  5  registered one-hot grant, 0 when idle
//  gnt_vld   out  1  registered; equals |gnt
//  gnt_idx   out  3  index of the granted bit (encoder_5b_3b of gnt); 0 when idle
//  timeout   out  1  1-cycle pulse: grant was force-released by MAX_HOLD
// BEHAVIOUR
//  Reset (async, rst_n=0), applied immediately:
//   gnt=0, gnt_vld=0, timeout=0, state=IDLE, hold_cnt=0, last=4.
//   last=4 gives requester 0 top priority after reset.
//  Reset mid-grant clears the grant at once; no pulse or state is preserved.
//  FSM states: IDLE, GRANT.
//  Pick: winner = first set bit of req scanning last+1, last+2, ... mod 5.
//  IDLE, any req set:
//   next edge gnt=onehot(winner), gnt_vld=1, state=GRANT, hold_cnt=0.
//   Latency is 1 cycle from req to gnt.
//  IDLE, req=0: hold state. done is ignored in IDLE.
//  GRANT, release event occurs on either of:
//   (a) done=1
//   (b) req[owner]=0
//   (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
//  On release:
//   last<=owner.
//   Re-pick from current req with owner masked out.
//   If the masked req is nonzero: the next edge loads the new winner (back-to-back, no idle cycle) and hold_cnt=0.
//   Otherwise: the owner may win again only if it alone requests and the release was (a) or (c).
//   If no winner: gnt=0, gnt_vld=0, state=IDLE.
//  timeout=1 for one cycle only on release cause (c) when neither (a) nor (b) holds in the same cycle.
//  Simultaneous (a)+(b) is a single release. A release and a new req in the same cycle: the new req joins that pick.
//  No release: hold_cnt increments, saturating at 2**CNT_W-1; gnt is stable.
//  Invariants: $onehot0(gnt) always; gnt_vld==|gnt; gnt changes only on the clk edge after a release.
//  Fairness: with all 5 requesting, each requester is granted exactly once per 5 grants.
// STRUCTURE
//  Shared include (arb_defs.vh): ARB_N=5, ARB_IDX_W=3, state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
//  Sub-module rr_pick_5: combinational; inputs req[4:0], mask[4:0], last[2:0]; outputs win[4:0] one-hot, any.
//  Index output: one encoder_5b_3b instance driven by gnt.
//  Top-level contents: FSM, hold counter, last pointer, output registers.
// TESTING
//  1 Reset release with req=5'b10100 -> 1 cycle later gnt=5'b00100, gnt_idx=2, gnt_vld=1.
//  2 req=5'b11111 held, done pulsed every 3 cycles -> grant order 0,1,2,3,4,0; each transition back-to-back, no idle cycle.
//  3 Owner 3 drops req while req=5'b01001 -> next edge gnt=5'b00001; timeout stays 0.
//  4 MAX_HOLD=4, req=5'b00011 held, no done:
//     gnt=00001 for 4 cycles, timeout pulses once, gnt=00010.
//     4 cycles later timeout pulses again and gnt=00001.
//  5 done and req[owner] fall in the same cycle, with req otherwise 0 -> single release, IDLE, gnt=0, no timeout.
//  6 rst_n low mid-grant (gnt=01000) -> gnt=0 asynchronously.
//     After release with req=5'b01000 -> gnt=01000 (last reset to 4).
//  Bench assertions, every cycle: onehot0(gnt), gnt_vld==|gnt, gnt_idx consistent with gnt.

Source files
------------

// File: rtl/rr_arbiter_5req_pkg.sv
// Shared constants and types for the 5-requester round-robin arbiter.
package rr_arbiter_5req_pkg;

    localparam int unsigned ARB_N     = 5;
    localparam int unsigned ARB_IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_5req_enc.sv
// One-hot (or zero) 5-bit grant to 3-bit index; zero input yields index 0.
module encoder_5b_3b
    import rr_arbiter_5req_pkg::*;
(
    input  logic [ARB_N-1:0]     onehot,
    output logic [ARB_IDX_W-1:0] idx
);

    assign idx[0] = onehot[1] | onehot[3];
    assign idx[1] = onehot[2] | onehot[3];
    assign idx[2] = onehot[4];

endmodule

// File: rtl/rr_arbiter_5req_pick.sv
// Combinational round-robin pick: first set bit of req & mask after position last.
module rr_pick_5
    import rr_arbiter_5req_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_N-1:0]     mask,
    input  logic [ARB_IDX_W-1:0] last,
    output logic [ARB_N-1:0]     win,
    output logic                 any
);

    logic [ARB_N-1:0] cand;
    logic [3:0]       pos;

    // Scan farthest-first so the nearest candidate after last overwrites the result.
    always_comb begin
        cand = req & mask;
        win  = '0;
        pos  = '0;
        for (int k = ARB_N; k >= 1; k--) begin
            pos = 4'(last) + 4'(k);
            if (pos >= 4'(ARB_N)) begin
                pos = pos - 4'(ARB_N);
            end
            if (cand[pos[ARB_IDX_W-1:0]]) begin
                win = ARB_N'(1) << pos;
            end
        end
    end

    assign any = |cand;

endmodule

// File: rtl/rr_arbiter_5req.sv
// 5-requester round-robin arbiter with a registered one-hot grant held until
// release by done, requester drop, or hold-time limit.
module rr_arbiter_5req
    import rr_arbiter_5req_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic [ARB_N-1:0]     gnt,
    output logic                 gnt_vld,
    output logic [ARB_IDX_W-1:0] gnt_idx,
    output logic                 timeout
);

    localparam logic             LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e           state_q, state_d;
    logic [ARB_N-1:0]     gnt_q, gnt_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [ARB_IDX_W-1:0] last_q, last_d;

    logic [ARB_IDX_W-1:0] owner;
    logic [ARB_N-1:0]     pick_mask;
    logic [ARB_IDX_W-1:0] pick_last;
    logic [ARB_N-1:0]     pick_win;
    logic                 pick_any;
    logic                 owner_req;
    logic                 rel_lim;
    logic                 rel;

    encoder_5b_3b u_enc (
        .onehot (gnt_q),
        .idx    (owner)
    );

    // While granted, the owner is masked and becomes the new last for the re-pick.
    assign pick_mask = (state_q == ST_GRANT) ? ~gnt_q : '1;
    assign pick_last = (state_q == ST_GRANT) ? owner  : last_q;

    rr_pick_5 u_pick (
        .req  (req),
        .mask (pick_mask),
        .last (pick_last),
        .win  (pick_win),
        .any  (pick_any)
    );

    assign owner_req = |(req & gnt_q);
    assign rel_lim   = LIMIT_EN && (hold_cnt_q == HOLD_LAST);
    assign rel       = done | ~owner_req | rel_lim;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d      = pick_win;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    last_d     = owner;
                    hold_cnt_d = '0;
                    timeout_d  = rel_lim & ~done & owner_req;
                    if (pick_any) begin
                        gnt_d = pick_win;
                    end else if (owner_req) begin
                        // Sole requester released by done or limit is granted again.
                        gnt_d = gnt_q;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        gnt_vld_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= ARB_IDX_W'(ARB_N - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_idx = owner;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_5req.sv
// Directed, table-driven bench for rr_arbiter_5req (default and MAX_HOLD=4 instances).
module tb_rr_arbiter_5req;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic       done = 1'b0;
    logic [4:0] gnt;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic       timeout;

    logic [4:0] req4 = '0;
    logic       done4 = 1'b0;
    logic [4:0] gnt4;
    logic       gnt_vld4;
    logic [2:0] gnt_idx4;
    logic       timeout4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter_5req u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .timeout (timeout)
    );

    rr_arbiter_5req #(.MAX_HOLD(4), .CNT_W(3)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req4),
        .done    (done4),
        .gnt     (gnt4),
        .gnt_vld (gnt_vld4),
        .gnt_idx (gnt_idx4),
        .timeout (timeout4)
    );

    typedef struct {
        logic [4:0] req;
        logic       done;
        logic [4:0] gnt;
        logic [2:0] idx;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [4:0] r, input logic d, input logic [4:0] g,
                                input logic [2:0] i, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.idx = i; v.to = t;
        vecs.push_back(v);
    endfunction

    function automatic logic [2:0] idx_of(input logic [4:0] g);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [4:0] eg, input logic [2:0] ei,
                             input logic et);
        check({tag, ".gnt"},     8'(gnt),     8'(eg));
        check({tag, ".gnt_vld"}, 8'(gnt_vld), 8'(|eg));
        check({tag, ".gnt_idx"}, 8'(gnt_idx), 8'(ei));
        check({tag, ".timeout"}, 8'(timeout), 8'(et));
    endtask

    // Structural invariants on both instances, sampled away from the rising edge.
    always @(negedge clk) begin
        check("inv.onehot0",  8'($onehot0(gnt)),  8'd1);
        check("inv.vld",      8'(gnt_vld),         8'(|gnt));
        check("inv.idx",      8'(gnt_idx),         8'(idx_of(gnt)));
        check("inv4.onehot0", 8'($onehot0(gnt4)), 8'd1);
        check("inv4.vld",     8'(gnt_vld4),        8'(|gnt4));
        check("inv4.idx",     8'(gnt_idx4),        8'(idx_of(gnt4)));
    end

    initial begin
        logic [4:0] eg4;

        // Reset state with requests already present.
        req = 5'b10100;
        step();
        check_out("reset", 5'b00000, 3'd0, 1'b0);

        // Grant one cycle after reset release; last=4 so requester 2 wins over 4.
        rst_n = 1'b1;
        step();
        check_out("t1", 5'b00100, 3'd2, 1'b0);
        req = '0;
        step();
        check_out("t1_idle", 5'b00000, 3'd0, 1'b0);

        // Hold limit 4: alternating grants with a timeout pulse on each forced release.
        req4 = 5'b00011;
        for (int i = 1; i <= 10; i++) begin
            step();
            eg4 = ((((i - 1) / 4) % 2) == 1) ? 5'b00010 : 5'b00001;
            check($sformatf("t4.gnt[%0d]", i), 8'(gnt4), 8'(eg4));
            check($sformatf("t4.to[%0d]", i), 8'(timeout4), 8'((i == 5) || (i == 9)));
        end
        req4 = '0;

        // Fresh reset so the table starts from last=4.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Round-robin with done every 3 cycles: 0,1,2,3,4,0 back-to-back.
        add(5'b11111, 0, 5'b00001, 3'd0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(5'b11111, 0, 5'(1) << ((k - 1) % 5), 3'((k - 1) % 5), 0);
            add(5'b11111, 1, 5'(1) << (k % 5), 3'(k % 5), 0);
            add(5'b11111, 0, 5'(1) << (k % 5), 3'(k % 5), 0);
        end
        // Owner 0 releases into 01001 -> 3; owner 3 drops -> 0, no timeout.
        add(5'b01001, 1, 5'b01000, 3'd3, 0);
        add(5'b01001, 0, 5'b01000, 3'd3, 0);
        add(5'b00001, 0, 5'b00001, 3'd0, 0);
        add(5'b00001, 0, 5'b00001, 3'd0, 0);
        // done and request drop together: single release to idle; done ignored in idle.
        add(5'b00000, 1, 5'b00000, 3'd0, 0);
        add(5'b00000, 0, 5'b00000, 3'd0, 0);
        add(5'b00000, 1, 5'b00000, 3'd0, 0);
        // Sole requester released by done is granted again.
        add(5'b00100, 0, 5'b00100, 3'd2, 0);
        add(5'b00100, 1, 5'b00100, 3'd2, 0);
        add(5'b00100, 0, 5'b00100, 3'd2, 0);
        // New request joins the release pick.
        add(5'b10100, 1, 5'b10000, 3'd4, 0);
        // Default limit 16: owner 4 held 16 cycles, then forced to 2 with timeout.
        for (int k = 0; k < 15; k++) add(5'b10100, 0, 5'b10000, 3'd4, 0);
        add(5'b10100, 0, 5'b00100, 3'd2, 1);
        add(5'b10100, 0, 5'b00100, 3'd2, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            req  = vecs[v].req;
            done = vecs[v].done;
            step();
            check_out($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].to);
        end
        done = 1'b0;

        // Owner 2 drops, 3 takes over; then asynchronous reset mid-grant.
        req = 5'b01000;
        step();
        check_out("t6_pre", 5'b01000, 3'd3, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("t6_async", 5'b00000, 3'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_out("t6_post", 5'b01000, 3'd3, 1'b0);

        // After reset last=4, so requester 0 beats 3.
        rst_n = 1'b0;
        req = 5'b01001;
        step();
        rst_n = 1'b1;
        step();
        check_out("t6_last", 5'b00001, 3'd0, 1'b0);

        req = '0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
